// File: rtl/dvp_tx_pkg.sv
// Shared definitions for the DVP pattern transmitter: FSM states, pattern codes,
// RGB565 colour-bar constants and the CRC-16/CCITT step used by the optional
// frame checksum (enabled with DVP_TX_CRC_EN).
package dvp_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_FRAME = 2'd3
  } pattern_e;

  // Colour bars, left to right, RGB565.
  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

  // One byte of CRC-16/CCITT, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] dat);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ dat[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Purpose: RGB565 test-pattern pixel for one (x, y) coordinate.
// Latency: 1 cycle (pixel_o registered).
// Backpressure: none; the transmitter free-runs at the byte clock.
// Ports: clk/rst (sync, active-high); x_i/y_i pixel coordinates; bar_i bar index;
//        sel_i frame-latched pattern; frame_i frame number; pixel_o pixel.
module dvp_pattern_gen
  import dvp_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic [2:0]  bar_i,
  input  pattern_e    sel_i,
  input  logic [5:0]  frame_i,
  output logic [15:0] pixel_o
);

  logic [15:0] pixel_d;
  logic [15:0] pixel_q;

  always_comb begin
    pixel_d = 16'h0000;
    case (sel_i)
      PAT_BARS:  pixel_d = bar_colour(bar_i);
      PAT_GRAD:  pixel_d = x_i + y_i;
      PAT_CHECK: pixel_d = (x_i[5] ^ y_i[5]) ? 16'hFFFF : 16'h0000;
      PAT_FRAME: pixel_d = {frame_i[4:0], frame_i, frame_i[4:0]};
      default:   pixel_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pixel_q <= 16'h0000;
    else     pixel_q <= pixel_d;
  end

  assign pixel_o = pixel_q;

endmodule

// File: rtl/dvp_pattern_tx.sv
// Purpose: OV5640-style DVP source (vsync/href/byte data, RGB565 high byte first).
// Latency: 2 cycles from h/v counters to all cam_* outputs, all stages matched.
// Backpressure: none; start/stop only on frame boundaries, enable is level-sensitive.
// Ports: clk, rst (sync, active-high), enable, pattern_sel -> cam_vsync, cam_href,
//        cam_data, frame_done, frame_cnt, busy; frame_crc when DVP_TX_CRC_EN is defined.
module dvp_pattern_tx
  import dvp_tx_pkg::*;
#(
  parameter int H_ACT    = 1024,
  parameter int V_ACT    = 768,
  parameter int H_TOTAL  = 2240,
  parameter int V_TOTAL  = 1272,
  parameter int VS_LINES = 4,
  parameter int V_START  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
`ifdef DVP_TX_CRC_EN
  ,
  output logic [15:0] frame_crc
`endif
);

  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int VW1       = VW + 1;
  localparam int BAR_BYTES = H_ACT / 4;   // H_ACT/8 pixels, 2 bytes each
  localparam int BW        = $clog2(BAR_BYTES);

  localparam logic [HW-1:0]  H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]  V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0]  HREF_END  = HW'(2 * H_ACT);
  localparam logic [VW1-1:0] VS_END    = VW1'(VS_LINES);
  localparam logic [VW1-1:0] VACT_BEG  = VW1'(V_START);
  localparam logic [VW1-1:0] VACT_END  = VW1'(V_START + V_ACT);
  localparam logic [BW-1:0]  BAR_LAST  = BW'(BAR_BYTES - 1);

  // ---------------------------------------------------------------- control
  state_e         state_q, state_d;
  logic [HW-1:0]  h_q, h_d;
  logic [VW-1:0]  v_q, v_d;
  logic [BW-1:0]  bar_cnt_q, bar_cnt_d;
  logic [2:0]     bar_q, bar_d;
  logic           run, h_last, v_last, frame_last, frame_start;

  assign run         = (state_q != ST_IDLE);
  assign h_last      = (h_q == H_LAST);
  assign v_last      = (v_q == V_LAST);
  assign frame_last  = run & h_last & v_last;
  assign frame_start = run & (h_q == '0) & (v_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_STOP;
      // Re-enable wins over the end-of-frame exit so back-to-back frames have no gap.
      ST_STOP: begin
        if (enable)          state_d = ST_RUN;
        else if (frame_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    h_d       = '0;
    v_d       = '0;
    bar_cnt_d = '0;
    bar_d     = '0;
    if (run) begin
      if (h_last) begin
        v_d = v_last ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
        v_d = v_q;
      end
    end
    // Bar index follows h without a divider; restarts whenever h returns to 0.
    if (h_d != '0) begin
      if (bar_cnt_q == BAR_LAST) begin
        bar_d = bar_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + BW'(1);
        bar_d     = bar_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      h_q       <= '0;
      v_q       <= '0;
      bar_cnt_q <= '0;
      bar_q     <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      bar_cnt_q <= bar_cnt_d;
      bar_q     <= bar_d;
    end
  end

  // ------------------------------------------------- per-frame latched values
  pattern_e    sel_q, sel_eff;
  logic [5:0]  fn_q, fn_eff;
  logic        last_a;
  logic [15:0] frame_cnt_q;

  // The pixel at h=v=0 already uses the freshly sampled values. On a
  // back-to-back frame the previous frame_done is still one stage away, so the
  // frame number is corrected by the in-flight last-byte flag.
  assign sel_eff = frame_start ? pattern_e'(pattern_sel) : sel_q;
  assign fn_eff  = frame_start ? (frame_cnt_q[5:0] + {5'b0, last_a}) : fn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= PAT_BARS;
      fn_q  <= '0;
    end else if (frame_start) begin
      sel_q <= sel_eff;
      fn_q  <= fn_eff;
    end
  end

  // ------------------------------------------------------ stage A: pixel
  logic [15:0] x_w, y_w, pixel_a;

  assign x_w = 16'(h_q[HW-1:1]);
  assign y_w = 16'(v_q) - 16'(V_START);

  dvp_pattern_gen u_gen (
    .clk     (clk),
    .rst     (rst),
    .x_i     (x_w),
    .y_i     (y_w),
    .bar_i   (bar_q),
    .sel_i   (sel_eff),
    .frame_i (fn_eff),
    .pixel_o (pixel_a)
  );

  logic vs_a, href_a, odd_a, busy_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_a   <= 1'b0;
      href_a <= 1'b0;
      odd_a  <= 1'b0;
      last_a <= 1'b0;
      busy_a <= 1'b0;
    end else begin
      vs_a   <= run & ({1'b0, v_q} < VS_END);
      href_a <= run & ({1'b0, v_q} >= VACT_BEG) & ({1'b0, v_q} < VACT_END) & (h_q < HREF_END);
      odd_a  <= h_q[0];
      last_a <= frame_last;
      busy_a <= run;
    end
  end

  // ---------------------------------------------------- stage B: outputs
  logic [7:0] data_d;
  logic       vs_q, href_q, done_q, busy_q;
  logic [7:0] data_q;

  always_comb begin
    data_d = 8'h00;
    if (href_a) data_d = odd_a ? pixel_a[7:0] : pixel_a[15:8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q        <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= 8'h00;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 16'h0000;
    end else begin
      vs_q        <= vs_a;
      href_q      <= href_a;
      data_q      <= data_d;
      done_q      <= last_a;
      busy_q      <= busy_a;
      frame_cnt_q <= frame_cnt_q + {15'b0, last_a};
    end
  end

  assign cam_vsync  = vs_q;
  assign cam_href   = href_q;
  assign cam_data   = data_q;
  assign frame_done = done_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = busy_q;

`ifdef DVP_TX_CRC_EN
  // Running CRC over href bytes; snapshot on the last byte, then restart.
  logic [15:0] crc_q, crc_next, frame_crc_q;

  assign crc_next = href_a ? crc16_byte(crc_q, data_d) : crc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q       <= CRC_INIT;
      frame_crc_q <= 16'h0000;
    end else if (last_a) begin
      crc_q       <= CRC_INIT;
      frame_crc_q <= crc_next;
    end else begin
      crc_q       <= crc_next;
    end
  end

  assign frame_crc = frame_crc_q;
`endif

endmodule
